rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the pipeline WB stage and a long-latency result source (mul/div, later load-miss return). WB always has priority and passes through with zero latency. Long-latency results are queued in a small FIFO and drained into idle write slots. A starvation counter forces a WB bubble when queued results wait too long. The block sits between WB / long-latency unit outputs and the register file write inputs.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- DEPTH, 2, FIFO entries; power of 2, ≥2
- STARVE_LIMIT, 4, consecutive blocked cycles of a live head before stall; ≥1
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wb_write_i  in  1  WB write request
- wb_addr_i  in  ADDR_W  WB destination
- wb_data_i  in  DATA_W  WB data
- lu_valid_i  in  1  long-latency result valid
- lu_addr_i  in  ADDR_W  long-latency destination
- lu_data_i  in  DATA_W  long-latency data
- lu_ready_o  out  1  FIFO can accept this cycle
- stall_o  out  1  registered; pipeline must present wb_write_i=0 in every cycle this is high
- rf_write_o  out  1  register file write enable
- rf_addr_o  out  ADDR_W  register file write address
- rf_data_o  out  DATA_W  register file write data
- fifo_count_o  out  log2(DEPTH)+1  occupied entries, live or dead

## Operation
- WB request is effective only when wb_write_i=1 and wb_addr_i≠0. Writes to x0 never use the port.
- Port select is combinational from current inputs and registered FIFO head:
  - WB effective: rf_* = wb_*.
  - Else head valid and live: rf_* = head, pop head.
  - Else rf_write_o=0, rf_addr_o=0, rf_data_o=0.
- Dead head pops on any cycle and never drives the port. It may pop in parallel with a WB write.
- lu_ready_o = reset_n and (count < DEPTH). Readiness does not depend on a same-cycle pop.
- Accept on lu_valid_i & lu_ready_o. Entries with lu_addr_i=0 are accepted and discarded without enqueueing.
- WAW squash: an effective WB write marks every buffered entry with equal addr dead. An entry accepted in the same cycle with equal addr is enqueued dead. WB is always younger in program order.
- Starvation counter:
  - Increments each cycle the head is live and not popped.
  - Clears on a pop, or when the head is dead or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_o next = (counter == STARVE_LIMIT) and live head not popped this cycle. stall_o falls the cycle after the head pops.
- If stall_o=1 and wb_write_i=1 (protocol violation), WB still wins. A simulation assertion flags it.

## Timing
- WB to rf_*: 0 cycles, combinational.
- Long-latency accept to earliest write: 1 cycle, i.e. the cycle after the accepting edge. There is no bypass from lu_* to rf_*.
- Continuous WB traffic with a live head: stall_o rises STARVE_LIMIT+1 cycles after the head becomes blocked. The head writes in the first stall_o=1 cycle.
- Simultaneous push and pop: count unchanged; FIFO order strictly preserved.
- Full: lu_ready_o=0, even if a pop occurs that cycle.
- Reset, asserted any time including mid-drain:
  - All entries dropped; count=0; starvation counter=0.
  - Outputs: lu_ready_o=0, stall_o=0, rf_write_o=0, rf_addr_o=0, rf_data_o=0, fifo_count_o=0.
  - All outputs held while reset_n=0.
  - First accept possible on the first rising edge after release.

## Structure
- Shared header holds the x0 address constant (ZERO_REG=0) and the default ADDR_W/DATA_W used by the register file, pipeline and this block.
- One sub-module, rf_write_fifo:
  - DEPTH entries of {addr, data, live}, with push/pop, head outputs and count.
  - Parallel address-compare squash input that clears live bits.
- Arbitration, starvation counter and stall register stay in rf_write_arbiter.

## Test plan
- WB only: wb_write_i=1, addr=5, data=0xDEAD → same cycle rf_write_o=1, rf_addr_o=5, rf_data_o=0xDEAD; FIFO untouched.
- Idle drain: push lu addr=7, data=0x11 with no WB → next cycle rf_write_o=1, addr=7, data=0x11; fifo_count_o returns 0.
- Starvation (STARVE_LIMIT=4): push addr=3, then WB writes to addr=9 every cycle → stall_o=1 after 5 blocked cycles. Bench drops WB; addr=3 written that cycle; stall_o=0 next cycle.
- WAW squash: push addr=4, data=0xA, then WB to addr=4, data=0xB → register 4 receives only 0xB; the dead entry pops with no port write.
- Full and x0: fill 2 entries → lu_ready_o=0 with fifo_count_o=2. lu push to addr=0 → count unchanged, no write. WB to addr=0 → rf_write_o=0 and head drains.
- Reset mid-operation: 2 entries queued and stall_o=1, pulse reset_n low between edges → all outputs 0 immediately; after release the queued entries are never written.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter_pkg
//   Shared definitions for the register-file write path: the x0 address
//   constant, the default address/data widths used by the register file,
//   the pipeline and the write arbiter, and the write-port source encoding.
// ----------------------------------------------------------------------------
package rf_write_arbiter_pkg;

  localparam int ZERO_REG   = 0;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // Which requester owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LU   = 2'd2
  } rf_src_e;

endpackage

// File: rtl/rf_write_fifo.sv
// ----------------------------------------------------------------------------
// rf_write_fifo
//   Small FIFO of pending long-latency results. Each entry holds
//   {addr, data, live}. A parallel squash input clears the live bit of every
//   entry whose address matches, so an older result never overwrites a newer
//   WB value.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   push, push_addr/data/live enqueue one entry (ignored when full)
//   pop                       dequeue the head (ignored when empty)
//   squash_en, squash_addr    kill all entries with matching address
//   head_valid/live/addr/data head entry view
//   count                     occupied entries, live or dead
// ----------------------------------------------------------------------------
module rf_write_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       push_live,
  input  logic                       pop,
  input  logic                       squash_en,
  input  logic [ADDR_W-1:0]          squash_addr,
  output logic                       head_valid,
  output logic                       head_live,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  live_mem;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok    = push && (count < CNT_W'(DEPTH));
  assign pop_ok     = pop && (count != '0);

  assign head_valid = (count != '0);
  assign head_live  = head_valid && live_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      live_mem <= '0;
    end else begin
      // Squash first; a same-cycle push into a freed slot overrides it below.
      if (squash_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_mem[i] == squash_addr) begin
            live_mem[i] <= 1'b0;
          end
        end
      end
      if (push_ok) begin
        live_mem[wr_ptr] <= push_live;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; the live bits and count gate its use.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// rf_write_arbiter
//   Shares the register file's single write port between the WB stage and a
//   long-latency result source. WB always wins with zero latency; long-latency
//   results are buffered and drained into idle slots. A starvation counter
//   requests a WB bubble (stall_o) when a live buffered result waits too long.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   wb_write_i, wb_addr_i, wb_data_i   WB write request
//   lu_valid_i, lu_addr_i, lu_data_i   long-latency result
//   lu_ready_o                         buffer can accept this cycle
//   stall_o                            registered WB bubble request
//   rf_write_o, rf_addr_o, rf_data_o   register file write port
//   fifo_count_o                       buffered entries, live or dead
// ----------------------------------------------------------------------------
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_write_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  input  logic                       lu_valid_i,
  input  logic [ADDR_W-1:0]          lu_addr_i,
  input  logic [DATA_W-1:0]          lu_data_i,
  output logic                       lu_ready_o,
  output logic                       stall_o,
  output logic                       rf_write_o,
  output logic [ADDR_W-1:0]          rf_addr_o,
  output logic [DATA_W-1:0]          rf_data_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic              wb_eff;
  logic              lu_accept;
  logic              fifo_push;
  logic              push_live;
  logic              fifo_pop;
  logic              head_valid;
  logic              head_live;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              head_blocked;
  rf_src_e           src_sel;

  logic [SC_W-1:0]   starve_cnt_p1;
  logic              stall_p1;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    if (v >= SC_W'(STARVE_LIMIT)) begin
      return SC_W'(STARVE_LIMIT);
    end
    return v + 1'b1;
  endfunction

  // Writes to x0 never reach the port; gating with reset_n keeps the port
  // quiet for the whole time reset is held.
  assign wb_eff     = reset_n && wb_write_i && (wb_addr_i != ADDR_W'(ZERO_REG));

  assign lu_ready_o = reset_n && (fifo_count < CNT_W'(DEPTH));
  assign lu_accept  = lu_valid_i && lu_ready_o;
  assign fifo_push  = lu_accept && (lu_addr_i != ADDR_W'(ZERO_REG));
  // WB is younger than any buffered or arriving result to the same register.
  assign push_live  = !(wb_eff && (lu_addr_i == wb_addr_i));

  // A dead head pops unconditionally; a live head only in a WB-free cycle.
  assign fifo_pop     = head_valid && (!head_live || !wb_eff);
  assign head_blocked = head_live && wb_eff;

  rf_write_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (fifo_push),
    .push_addr   (lu_addr_i),
    .push_data   (lu_data_i),
    .push_live   (push_live),
    .pop         (fifo_pop),
    .squash_en   (wb_eff),
    .squash_addr (wb_addr_i),
    .head_valid  (head_valid),
    .head_live   (head_live),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (fifo_count)
  );

  always_comb begin
    src_sel = SRC_NONE;
    if (wb_eff) begin
      src_sel = SRC_WB;
    end else if (head_live) begin
      src_sel = SRC_LU;
    end
  end

  always_comb begin
    rf_write_o = 1'b0;
    rf_addr_o  = '0;
    rf_data_o  = '0;
    case (src_sel)
      SRC_WB: begin
        rf_write_o = 1'b1;
        rf_addr_o  = wb_addr_i;
        rf_data_o  = wb_data_i;
      end
      SRC_LU: begin
        rf_write_o = 1'b1;
        rf_addr_o  = head_addr;
        rf_data_o  = head_data;
      end
      default: ;
    endcase
  end

  assign fifo_count_o = fifo_count;
  assign stall_o      = stall_p1;

  // ---- stage p1: starvation counter and stall request ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_p1 <= '0;
      stall_p1      <= 1'b0;
    end else begin
      starve_cnt_p1 <= head_blocked ? sat_inc(starve_cnt_p1) : '0;
      stall_p1      <= head_blocked && (starve_cnt_p1 == SC_W'(STARVE_LIMIT));
    end
  end

  // The pipeline must not issue WB while a bubble is requested.
  a_no_wb_during_stall : assert property (
    @(posedge clk) disable iff (!reset_n) !(stall_o && wb_write_i)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_write_arbiter
//   Directed bench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4). Expected
//   port writes go into a queue as stimulus is issued; a negedge monitor pops
//   and compares whenever rf_write_o is high. Status outputs are checked
//   inline by the stimulus process.
// ----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int SLIM   = 4;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wb_write_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              lu_valid_i;
  logic [ADDR_W-1:0] lu_addr_i;
  logic [DATA_W-1:0] lu_data_i;
  logic              lu_ready_o;
  logic              stall_o;
  logic              rf_write_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  rf_write_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (SLIM)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_write_i   (wb_write_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .lu_valid_i   (lu_valid_i),
    .lu_addr_i    (lu_addr_i),
    .lu_data_i    (lu_data_i),
    .lu_ready_o   (lu_ready_o),
    .stall_o      (stall_o),
    .rf_write_o   (rf_write_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the
  // following falling edge where outputs are stable.
  task automatic apply(input logic ww, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    @(posedge clk);
    #1;
    wb_write_i = ww; wb_addr_i = wa; wb_data_i = wd;
    lu_valid_i = lv; lu_addr_i = la; lu_data_i = ld;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wb_write_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    lu_valid_i = 1'b0; lu_addr_i = '0; lu_data_i = '0;
  endtask

  // Scoreboard monitor: every port write must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_write_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 rf_addr_o, rf_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rf_addr_o !== e.a || rf_data_o !== e.d) begin
          errors++;
          $display("FAIL rf_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   rf_addr_o, rf_data_o, e.a, e.d);
        end
      end
    end
  end

  initial begin
    int  nwb;
    bit  got;

    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_lu_ready", 32'(lu_ready_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_rf_write", 32'(rf_write_o), 0);
    chk("rst_count", 32'(fifo_count_o), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // WB only: zero-latency pass-through, buffer untouched.
    expect_wr(5, 32'hDEAD);
    apply(1, 5, 32'hDEAD, 0, 0, 0);
    chk("wb_only_count", 32'(fifo_count_o), 0);
    chk("wb_only_ready", 32'(lu_ready_o), 1);

    // Idle drain: accepted result writes the cycle after the accept.
    apply(0, 0, 0, 1, 7, 32'h11);
    chk("drain_no_bypass", 32'(rf_write_o), 0);
    expect_wr(7, 32'h11);
    apply(0, 0, 0, 0, 0, 0);
    chk("drain_count_1", 32'(fifo_count_o), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("drain_count_0", 32'(fifo_count_o), 0);

    // Starvation: head addr 3 blocked by continuous WB to addr 9.
    apply(0, 0, 0, 1, 3, 32'h33);
    nwb = 0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (stall_o) begin
        got = 1'b1;
        break;
      end
      wb_write_i = 1'b1; wb_addr_i = 9; wb_data_i = 32'(i + 32'h90);
      lu_valid_i = 1'b0;
      expect_wr(9, 32'(i + 32'h90));
      nwb++;
      @(negedge clk);
    end
    if (got) expect_wr(3, 32'h33);
    clear_inputs();
    @(negedge clk);
    chk("starve_stall_rise", 32'(got), 1);
    chk("starve_blocked_cycles", 32'(nwb), SLIM + 1);
    chk("starve_stall_high", 32'(stall_o), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("starve_stall_fall", 32'(stall_o), 0);
    chk("starve_count", 32'(fifo_count_o), 0);

    // WAW squash of a buffered entry.
    apply(0, 0, 0, 1, 4, 32'hA);
    expect_wr(4, 32'hB);
    apply(1, 4, 32'hB, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("waw_dead_no_write", 32'(rf_write_o), 0);
    chk("waw_dead_count", 32'(fifo_count_o), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("waw_drained", 32'(fifo_count_o), 0);

    // WAW squash of an entry accepted in the same cycle.
    expect_wr(6, 32'hC);
    apply(1, 6, 32'hC, 1, 6, 32'hD);
    apply(0, 0, 0, 0, 0, 0);
    chk("waw_same_no_write", 32'(rf_write_o), 0);
    chk("waw_same_count", 32'(fifo_count_o), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("waw_same_drained", 32'(fifo_count_o), 0);

    // Full, order, and x0 handling.
    expect_wr(20, 32'h200);
    apply(1, 20, 32'h200, 1, 10, 32'h100);
    expect_wr(21, 32'h201);
    apply(1, 21, 32'h201, 1, 11, 32'h101);
    chk("fill_count_1", 32'(fifo_count_o), 1);
    expect_wr(22, 32'h202);
    apply(1, 22, 32'h202, 1, 12, 32'h102);
    chk("full_count", 32'(fifo_count_o), 2);
    chk("full_ready", 32'(lu_ready_o), 0);
    expect_wr(10, 32'h100);
    apply(1, 0, 32'hBAD, 1, 12, 32'h102);
    chk("full_pop_ready", 32'(lu_ready_o), 0);
    expect_wr(11, 32'h101);
    apply(0, 0, 0, 1, 0, 32'h55);
    chk("x0_pre_count", 32'(fifo_count_o), 1);
    chk("x0_ready", 32'(lu_ready_o), 1);
    apply(0, 0, 0, 0, 0, 0);
    chk("x0_count", 32'(fifo_count_o), 0);
    chk("x0_no_write", 32'(rf_write_o), 0);

    // Reset mid-operation with two queued entries and stall_o high.
    expect_wr(23, 32'h203);
    apply(1, 23, 32'h203, 1, 13, 32'h103);
    expect_wr(24, 32'h204);
    apply(1, 24, 32'h204, 1, 14, 32'h104);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (stall_o) begin
        got = 1'b1;
        break;
      end
      wb_write_i = 1'b1; wb_addr_i = 25; wb_data_i = 32'(i + 32'h250);
      lu_valid_i = 1'b0;
      expect_wr(25, 32'(i + 32'h250));
      @(negedge clk);
    end
    clear_inputs();
    chk("rstmid_stall", 32'(got), 1);
    chk("rstmid_count", 32'(fifo_count_o), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_lu_ready", 32'(lu_ready_o), 0);
    chk("rstmid_stall_low", 32'(stall_o), 0);
    chk("rstmid_rf_write", 32'(rf_write_o), 0);
    chk("rstmid_rf_addr", 32'(rf_addr_o), 0);
    chk("rstmid_rf_data", rf_data_o, 0);
    chk("rstmid_fifo_count", 32'(fifo_count_o), 0);
    #1 reset_n = 1'b1;
    lu_valid_i = 1'b1; lu_addr_i = 15; lu_data_i = 32'h77;
    @(negedge clk);
    chk("post_rst_ready", 32'(lu_ready_o), 1);
    chk("post_rst_no_write", 32'(rf_write_o), 0);
    expect_wr(15, 32'h77);
    apply(0, 0, 0, 0, 0, 0);
    repeat (3) apply(0, 0, 0, 0, 0, 0);
    chk("post_rst_count", 32'(fifo_count_o), 0);
    chk("exp_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
